// File: rtl/mxu_pkg.sv
// Shared types and defaults for the mxu host driver.
// Imported by the driver, its interface and the testbench.
package mxu_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    WAIT,
    ADDR,
    CAPT,
    PUSH
  } mxu_drv_state_t;

  localparam int DEF_SIZE     = 4;
  localparam int NUM_ACC      = DEF_SIZE * DEF_SIZE;
  localparam int DEF_TIMEOUT  = 1024;
  localparam int DEF_READ_LAT = 1;

  function automatic int numAcc(input int size);
    return size * size;
  endfunction

endpackage

// File: rtl/mxu_host_driver_if.sv
// Bundle of the host command port, the mxu control/read port and the result stream.
// The master modport is the driver's view; the slave modport is the host/mxu side.
interface mxu_host_driver_if import mxu_pkg::*; #(
  parameter int SIZE  = DEF_SIZE,
  parameter int IDX_W = $clog2(SIZE * SIZE)
);

  logic                     cmd_valid;
  logic                     cmd_ready;
  logic [SIZE*SIZE*8-1:0]   cmd_a;
  logic [SIZE*SIZE*8-1:0]   cmd_b;
  logic                     cmd_cycles;

  logic [SIZE*SIZE*8-1:0]   data_a_o;
  logic [SIZE*SIZE*8-1:0]   data_b_o;
  logic                     cycles_o;
  logic                     start_o;
  logic                     done_i;
  logic [31:0]              araddr_o;
  logic [31:0]              rdata_i;

  logic                     out_valid;
  logic                     out_ready;
  logic [31:0]              out_data;
  logic [IDX_W-1:0]         out_index;
  logic                     out_last;

  logic                     busy;
  logic                     err_timeout;

  modport master (
    input  cmd_valid, cmd_a, cmd_b, cmd_cycles, done_i, rdata_i, out_ready,
    output cmd_ready, data_a_o, data_b_o, cycles_o, start_o, araddr_o,
           out_valid, out_data, out_index, out_last, busy, err_timeout
  );

  modport slave (
    output cmd_valid, cmd_a, cmd_b, cmd_cycles, done_i, rdata_i, out_ready,
    input  cmd_ready, data_a_o, data_b_o, cycles_o, start_o, araddr_o,
           out_valid, out_data, out_index, out_last, busy, err_timeout
  );

endinterface

// File: rtl/mxu_host_driver.sv
// Initiator-side driver for one mxu: takes a command, starts the unit, waits for done,
// then reads every accumulator back and streams it out with index and last flags.
module mxu_host_driver import mxu_pkg::*; #(
  parameter int SIZE     = DEF_SIZE,
  parameter int READ_LAT = DEF_READ_LAT,
  parameter int TIMEOUT  = DEF_TIMEOUT,
  parameter int IDX_W    = $clog2(SIZE * SIZE)
) (
  input logic             clk,
  input logic             reset,
  mxu_host_driver_if.master bus
);

  localparam int NACC = numAcc(SIZE);
  localparam int OPW  = NACC * 8;
  localparam int TW   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [IDX_W-1:0] LAST_K   = IDX_W'(NACC - 1);
  localparam logic [TW-1:0]    WAIT_MAX = TW'(TIMEOUT - 1);
  localparam logic [1:0]       LAT_INIT = 2'(READ_LAT);

  mxu_drv_state_t   state_q, state_d;
  logic [OPW-1:0]   dataA_q, dataA_d;
  logic [OPW-1:0]   dataB_q, dataB_d;
  logic             cycles_q, cycles_d;
  logic [31:0]      araddr_q, araddr_d;
  logic [31:0]      outData_q, outData_d;
  logic [IDX_W-1:0] k_q, k_d;
  logic [TW-1:0]    waitCnt_q, waitCnt_d;
  logic [1:0]       latCnt_q, latCnt_d;
  logic             errTimeout_q, errTimeout_d;
  logic [31:0]      araddrNow;
  logic [31:0]      readAddr;

  // mxu decodes accumulator select as araddr-1, so address k lives at k+1.
  assign readAddr = {{(32-IDX_W){1'b0}}, k_q} + 32'd1;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= IDLE;
      dataA_q      <= '0;
      dataB_q      <= '0;
      cycles_q     <= 1'b0;
      araddr_q     <= '0;
      outData_q    <= '0;
      k_q          <= '0;
      waitCnt_q    <= '0;
      latCnt_q     <= '0;
      errTimeout_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      dataA_q      <= dataA_d;
      dataB_q      <= dataB_d;
      cycles_q     <= cycles_d;
      araddr_q     <= araddr_d;
      outData_q    <= outData_d;
      k_q          <= k_d;
      waitCnt_q    <= waitCnt_d;
      latCnt_q     <= latCnt_d;
      errTimeout_q <= errTimeout_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    dataA_d      = dataA_q;
    dataB_d      = dataB_q;
    cycles_d     = cycles_q;
    araddr_d     = araddr_q;
    outData_d    = outData_q;
    k_d          = k_q;
    waitCnt_d    = waitCnt_q;
    latCnt_d     = latCnt_q;
    errTimeout_d = 1'b0;
    araddrNow    = araddr_q;

    case (state_q)
      IDLE: begin
        if (bus.cmd_valid) begin
          dataA_d  = bus.cmd_a;
          dataB_d  = bus.cmd_b;
          cycles_d = bus.cmd_cycles;
          state_d  = START;
        end
      end
      START: begin
        waitCnt_d = '0;
        state_d   = WAIT;
      end
      WAIT: begin
        // done takes priority over a timeout landing on the same cycle
        if (bus.done_i) begin
          k_d     = '0;
          state_d = ADDR;
        end else if (waitCnt_q == WAIT_MAX) begin
          errTimeout_d = 1'b1;
          state_d      = IDLE;
        end else begin
          waitCnt_d = waitCnt_q + 1'b1;
        end
      end
      ADDR: begin
        // Address is presented combinationally so a zero-latency read lands this cycle.
        araddrNow = readAddr;
        araddr_d  = readAddr;
        if (READ_LAT == 0) begin
          outData_d = bus.rdata_i;
          state_d   = PUSH;
        end else begin
          latCnt_d = LAT_INIT;
          state_d  = CAPT;
        end
      end
      CAPT: begin
        latCnt_d = latCnt_q - 2'd1;
        if (latCnt_q == 2'd1) begin
          outData_d = bus.rdata_i;
          state_d   = PUSH;
        end
      end
      PUSH: begin
        if (bus.out_ready) begin
          if (k_q == LAST_K) begin
            state_d = IDLE;
          end else begin
            k_d     = k_q + 1'b1;
            state_d = ADDR;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.cmd_ready   = (state_q == IDLE);
  assign bus.busy        = (state_q != IDLE);
  assign bus.start_o     = (state_q == START);
  assign bus.out_valid   = (state_q == PUSH);
  assign bus.out_last    = (state_q == PUSH) && (k_q == LAST_K);
  assign bus.out_index   = k_q;
  assign bus.out_data    = outData_q;
  assign bus.araddr_o    = araddrNow;
  assign bus.data_a_o    = dataA_q;
  assign bus.data_b_o    = dataB_q;
  assign bus.cycles_o    = cycles_q;
  assign bus.err_timeout = errTimeout_q;

endmodule

// File: tb/tb_mxu_host_driver.sv
// Directed bench for mxu_host_driver: four drivers (READ_LAT 1,0,2,3) each behind a mock mxu
// whose rdata is 0x1000 + (araddr-1) after READ_LAT cycles and whose done fires 20 cycles after start.
module tb_mxu_host_driver;
  import mxu_pkg::*;

  localparam int SIZE  = 4;
  localparam int NACC  = 16;
  localparam int OPW   = 128;
  localparam int IDX_W = 4;
  localparam int NINST = 4;
  localparam int TMO   = 64;
  localparam int MAXB  = 32;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic [NINST-1:0] cmdValid = '0;
  logic [OPW-1:0]   cmdA = '0;
  logic [OPW-1:0]   cmdB = '0;
  logic             cmdCycles = 1'b0;
  logic             outReady = 1'b1;
  logic             readyMode = 1'b0;
  int               rdyPh = 0;
  logic             doneEnable = 1'b1;
  logic             monClear = 1'b1;
  int               cycleCnt = 0;

  int numCompared = 0;
  int numMismatched = 0;

  logic [NINST-1:0] obsReady, obsValid, obsStart, obsBusy, obsErr, obsLast, obsCycles;
  logic [31:0]      obsData [NINST];
  logic [31:0]      obsAddr [NINST];
  logic [IDX_W-1:0] obsIdx  [NINST];
  logic [OPW-1:0]   obsDataA [NINST];
  logic [OPW-1:0]   obsDataB [NINST];

  int               beatCnt  [NINST];
  logic [31:0]      beatData [NINST][MAXB];
  logic [31:0]      beatAddr [NINST][MAXB];
  int               beatIdx  [NINST][MAXB];
  logic             beatLast [NINST][MAXB];
  int               beatCyc  [NINST][MAXB];
  int               startCnt [NINST];
  int               startCyc [NINST];
  int               errCnt   [NINST];
  int               errCyc   [NINST];
  logic             readyAtErr [NINST];
  int               stallViol [NINST];
  logic             stallHeld [NINST];
  logic [31:0]      stallData [NINST];
  logic [IDX_W-1:0] stallIdx  [NINST];

  always @(posedge clk) cycleCnt <= cycleCnt + 1;

  for (genvar g = 0; g < NINST; g++) begin : gInst
    localparam int LAT = (g == 0) ? 1 : ((g == 1) ? 0 : g);

    mxu_host_driver_if #(.SIZE(SIZE), .IDX_W(IDX_W)) ifc ();

    mxu_host_driver #(
      .SIZE(SIZE), .READ_LAT(LAT), .TIMEOUT(TMO), .IDX_W(IDX_W)
    ) dut (
      .clk(clk),
      .reset(reset),
      .bus(ifc.master)
    );

    logic [31:0] pipe [4];
    int          doneCnt;
    logic [31:0] mockAddr;

    assign ifc.cmd_valid  = cmdValid[g];
    assign ifc.cmd_a      = cmdA;
    assign ifc.cmd_b      = cmdB;
    assign ifc.cmd_cycles = cmdCycles;
    assign ifc.out_ready  = outReady;
    assign ifc.done_i     = doneEnable && (doneCnt == 20);
    assign ifc.rdata_i    = 32'h1000 + mockAddr - 32'd1;

    if (LAT == 0) begin : gComb
      assign mockAddr = ifc.araddr_o;
    end else begin : gPipe
      assign mockAddr = pipe[LAT-1];
    end

    // mock mxu: read pipeline and done timer
    always @(posedge clk) begin
      pipe[0] <= ifc.araddr_o;
      for (int i = 1; i < 4; i++) pipe[i] <= pipe[i-1];
      if (!reset) doneCnt <= 0;
      else if (ifc.start_o) doneCnt <= 1;
      else if (doneCnt == 20) doneCnt <= 0;
      else if (doneCnt != 0) doneCnt <= doneCnt + 1;
    end

    assign obsReady[g]  = ifc.cmd_ready;
    assign obsValid[g]  = ifc.out_valid;
    assign obsStart[g]  = ifc.start_o;
    assign obsBusy[g]   = ifc.busy;
    assign obsErr[g]    = ifc.err_timeout;
    assign obsLast[g]   = ifc.out_last;
    assign obsCycles[g] = ifc.cycles_o;
    assign obsData[g]   = ifc.out_data;
    assign obsAddr[g]   = ifc.araddr_o;
    assign obsIdx[g]    = ifc.out_index;
    assign obsDataA[g]  = ifc.data_a_o;
    assign obsDataB[g]  = ifc.data_b_o;

    // monitor samples mid-cycle, records handshakes, starts, timeouts and stall stability
    always @(negedge clk) begin
      if (monClear) begin
        beatCnt[g]   <= 0;
        startCnt[g]  <= 0;
        errCnt[g]    <= 0;
        stallViol[g] <= 0;
        stallHeld[g] <= 1'b0;
      end else if (reset) begin
        if (ifc.start_o) begin
          startCnt[g] <= startCnt[g] + 1;
          startCyc[g] <= cycleCnt;
        end
        if (ifc.err_timeout) begin
          errCnt[g]     <= errCnt[g] + 1;
          errCyc[g]     <= cycleCnt;
          readyAtErr[g] <= ifc.cmd_ready;
        end
        if (stallHeld[g] && (!ifc.out_valid || ifc.out_data != stallData[g] ||
                             ifc.out_index != stallIdx[g]))
          stallViol[g] <= stallViol[g] + 1;
        stallHeld[g] <= ifc.out_valid && !outReady;
        stallData[g] <= ifc.out_data;
        stallIdx[g]  <= ifc.out_index;
        if (ifc.out_valid && outReady && beatCnt[g] < MAXB) begin
          beatData[g][beatCnt[g]] <= ifc.out_data;
          beatAddr[g][beatCnt[g]] <= ifc.araddr_o;
          beatIdx[g][beatCnt[g]]  <= int'(ifc.out_index);
          beatLast[g][beatCnt[g]] <= ifc.out_last;
          beatCyc[g][beatCnt[g]]  <= cycleCnt;
          beatCnt[g]              <= beatCnt[g] + 1;
        end
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [127:0] observed,
                             input logic [127:0] expected);
    numCompared++;
    if (observed !== expected) begin
      numMismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
    if (readyMode) begin
      rdyPh    = (rdyPh == 2) ? 0 : rdyPh + 1;
      outReady = (rdyPh == 0);
    end else begin
      outReady = 1'b1;
    end
  endtask

  task automatic clearMon();
    monClear = 1'b1;
    tick();
    monClear = 1'b0;
  endtask

  task automatic applyStimulus(input logic [NINST-1:0] mask, input logic [OPW-1:0] a,
                               input logic [OPW-1:0] b, input logic cyc);
    cmdA      = a;
    cmdB      = b;
    cmdCycles = cyc;
    cmdValid  = mask;
  endtask

  task automatic waitBeats(input int g, input int n, input int budget);
    int spent = 0;
    while (beatCnt[g] < n && spent < budget) begin
      tick();
      spent++;
    end
    checkOutput($sformatf("beats reached inst%0d", g), 128'(beatCnt[g]), 128'(n));
  endtask

  task automatic checkResetState(input int g);
    checkOutput("rst cmd_ready",   128'(obsReady[g]), 128'(1));
    checkOutput("rst busy",        128'(obsBusy[g]), 128'(0));
    checkOutput("rst start_o",     128'(obsStart[g]), 128'(0));
    checkOutput("rst out_valid",   128'(obsValid[g]), 128'(0));
    checkOutput("rst err_timeout", 128'(obsErr[g]), 128'(0));
    checkOutput("rst out_last",    128'(obsLast[g]), 128'(0));
    checkOutput("rst araddr_o",    128'(obsAddr[g]), 128'(0));
    checkOutput("rst out_data",    128'(obsData[g]), 128'(0));
    checkOutput("rst out_index",   128'(obsIdx[g]), 128'(0));
    checkOutput("rst data_a_o",    obsDataA[g], 128'(0));
    checkOutput("rst data_b_o",    obsDataB[g], 128'(0));
    checkOutput("rst cycles_o",    128'(obsCycles[g]), 128'(0));
  endtask

  task automatic checkSweep(input int g, input string tag);
    for (int i = 0; i < NACC; i++) begin
      checkOutput($sformatf("%s data[%0d]", tag, i), 128'(beatData[g][i]), 128'(32'h1000 + i));
      checkOutput($sformatf("%s index[%0d]", tag, i), 128'(beatIdx[g][i]), 128'(i));
      checkOutput($sformatf("%s last[%0d]", tag, i), 128'(beatLast[g][i]), 128'(i == NACC - 1));
      checkOutput($sformatf("%s araddr[%0d]", tag, i), 128'(beatAddr[g][i]), 128'(i + 1));
    end
  endtask

  task automatic checkSpacing(input int g, input int spacing, input string tag);
    int bad = 0;
    for (int i = 1; i < NACC; i++)
      if (beatCyc[g][i] - beatCyc[g][i-1] != spacing) bad++;
    checkOutput($sformatf("%s first spacing", tag), 128'(beatCyc[g][1] - beatCyc[g][0]),
                128'(spacing));
    checkOutput($sformatf("%s bad spacings", tag), 128'(bad), 128'(0));
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [OPW-1:0] a1, b1, a2, b2;
    int spent, earlyReady, changedA, allDone;
    int expSpacing [NINST];
    a1 = 128'h0f0e0d0c_0b0a0908_07060504_03020100;
    b1 = 128'h11223344_55667788_99aabbcc_ddeeff00;
    a2 = 128'hdeadbeef_cafef00d_01234567_89abcdef;
    b2 = 128'h80706050_40302010_0f1e2d3c_4b5a6978;
    expSpacing[0] = 3;
    expSpacing[1] = 2;
    expSpacing[2] = 4;
    expSpacing[3] = 5;

    repeat (3) tick();
    checkResetState(0);
    checkResetState(3);
    reset = 1'b1;
    tick();
    monClear = 1'b0;

    $display("[TB] basic sweep, READ_LAT=1, out_ready high");
    applyStimulus(4'b0001, a1, b1, 1'b1);
    tick();
    cmdValid = '0;
    checkOutput("accept start_o", 128'(obsStart[0]), 128'(1));
    checkOutput("accept cmd_ready", 128'(obsReady[0]), 128'(0));
    checkOutput("accept busy", 128'(obsBusy[0]), 128'(1));
    checkOutput("accept data_a_o", obsDataA[0], a1);
    checkOutput("accept data_b_o", obsDataB[0], b1);
    checkOutput("accept cycles_o", 128'(obsCycles[0]), 128'(1));
    tick();
    checkOutput("start one cycle", 128'(obsStart[0]), 128'(0));
    waitBeats(0, NACC, 300);
    checkOutput("idle after sweep cmd_ready", 128'(obsReady[0]), 128'(1));
    checkOutput("idle after sweep out_valid", 128'(obsValid[0]), 128'(0));
    checkOutput("araddr held in idle", 128'(obsAddr[0]), 128'(16));
    checkOutput("start pulse count", 128'(startCnt[0]), 128'(1));
    checkSweep(0, "basic");
    checkSpacing(0, 3, "basic");

    $display("[TB] sweep with out_ready 1-in-3");
    clearMon();
    readyMode = 1'b1;
    applyStimulus(4'b0001, a1, b1, 1'b0);
    tick();
    cmdValid = '0;
    waitBeats(0, NACC, 600);
    repeat (10) tick();
    readyMode = 1'b0;
    checkOutput("stall beat count", 128'(beatCnt[0]), 128'(NACC));
    checkOutput("stall stability", 128'(stallViol[0]), 128'(0));
    checkSweep(0, "stall");

    $display("[TB] timeout with done suppressed");
    clearMon();
    doneEnable = 1'b0;
    applyStimulus(4'b0001, a2, b2, 1'b0);
    tick();
    cmdValid = '0;
    spent = 0;
    while (errCnt[0] == 0 && spent < 150) begin
      tick();
      spent++;
    end
    repeat (5) tick();
    checkOutput("timeout pulse count", 128'(errCnt[0]), 128'(1));
    checkOutput("timeout delay from start", 128'(errCyc[0] - startCyc[0]), 128'(65));
    checkOutput("timeout cmd_ready", 128'(readyAtErr[0]), 128'(1));
    checkOutput("timeout no beats", 128'(beatCnt[0]), 128'(0));
    checkOutput("timeout busy", 128'(obsBusy[0]), 128'(0));
    doneEnable = 1'b1;

    $display("[TB] reset during beat 7");
    clearMon();
    applyStimulus(4'b0001, a1, b1, 1'b1);
    tick();
    cmdValid = '0;
    spent = 0;
    while (!(obsValid[0] && obsIdx[0] == 4'd7) && spent < 200) begin
      tick();
      spent++;
    end
    checkOutput("beats before reset", 128'(beatCnt[0]), 128'(7));
    reset = 1'b0;
    tick();
    checkResetState(0);
    reset = 1'b1;
    repeat (3) tick();
    checkOutput("no beats after reset", 128'(beatCnt[0]), 128'(7));
    clearMon();
    applyStimulus(4'b0001, a2, b2, 1'b0);
    tick();
    cmdValid = '0;
    waitBeats(0, NACC, 300);
    checkSweep(0, "post-reset");

    $display("[TB] second command held during first job");
    clearMon();
    applyStimulus(4'b0001, a1, b1, 1'b0);
    tick();
    cmdA = a2;
    cmdB = b2;
    spent = 0;
    earlyReady = 0;
    changedA = 0;
    while (beatCnt[0] < NACC && spent < 300) begin
      if (obsReady[0]) earlyReady++;
      if (obsDataA[0] != a1) changedA++;
      tick();
      spent++;
    end
    checkOutput("held cmd_ready stays low", 128'(earlyReady), 128'(0));
    checkOutput("held data_a stable", 128'(changedA), 128'(0));
    checkOutput("held ready after last", 128'(obsReady[0]), 128'(1));
    checkOutput("held data_a before accept", obsDataA[0], a1);
    tick();
    cmdValid = '0;
    checkOutput("held second accept data_a", obsDataA[0], a2);
    checkOutput("held second accept data_b", obsDataB[0], b2);
    checkOutput("held second start", 128'(obsStart[0]), 128'(1));
    clearMon();
    waitBeats(0, NACC, 300);
    checkSweep(0, "second job");

    $display("[TB] READ_LAT sweep 1/0/2/3");
    clearMon();
    applyStimulus(4'b1111, a1, b1, 1'b0);
    tick();
    cmdValid = '0;
    spent = 0;
    allDone = 0;
    while (allDone == 0 && spent < 400) begin
      allDone = 1;
      for (int g = 0; g < NINST; g++)
        if (beatCnt[g] < NACC) allDone = 0;
      tick();
      spent++;
    end
    for (int g = 0; g < NINST; g++) begin
      checkOutput($sformatf("lat beats inst%0d", g), 128'(beatCnt[g]), 128'(NACC));
      checkSweep(g, $sformatf("lat inst%0d", g));
      checkSpacing(g, expSpacing[g], $sformatf("lat inst%0d", g));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", numCompared, numMismatched);
    $finish;
  end

endmodule
